// File: rtl/us_ip_rx_demux.sv
// IP payload receive demultiplexer: routes whole packets to one of NUM_CH AXIS
// outputs by protocol code, with optional per-channel byte swap and drop/error counters.
module us_ip_rx_demux #(
    parameter int                   DATA_W   = 64,
    parameter int                   NUM_CH   = 2,
    parameter logic [NUM_CH*16-1:0] CH_PROTO = {16'h0001, 16'h0011},
    parameter logic [NUM_CH-1:0]    CH_BSWAP = 2'b01,
    localparam int                  KEEP_W   = DATA_W / 8
) (
    input  logic                     rx_axis_aclk,
    input  logic                     rx_axis_reset,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic [KEEP_W-1:0]        s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    input  logic [15:0]              recv_type,
    input  logic [31:0]              recv_src_ip_addr,
    input  logic [31:0]              recv_dst_ip_addr,
    output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
    output logic [NUM_CH*KEEP_W-1:0] m_axis_tkeep,
    output logic [NUM_CH-1:0]        m_axis_tvalid,
    input  logic [NUM_CH-1:0]        m_axis_tready,
    output logic [NUM_CH-1:0]        m_axis_tuser,
    output logic [NUM_CH-1:0]        m_axis_tlast,
    output logic [31:0]              ip_mode_src_addr,
    output logic [31:0]              ip_mode_dst_addr,
    output logic [31:0]              drop_pkt_cnt,
    output logic [31:0]              err_pkt_cnt
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DROP
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     sel;

    // Single shared output register; out_oh doubles as the one-hot valid vector.
    logic [NUM_CH-1:0]   out_oh;
    logic [DATA_W-1:0]   out_data;
    logic [KEEP_W-1:0]   out_keep;
    logic                out_last;
    logic                out_user;

    logic                hit;
    logic [CH_W-1:0]     match_ch;
    logic [CH_W-1:0]     route_ch;
    logic [NUM_CH-1:0]   route_oh;
    logic                do_swap;
    logic [DATA_W-1:0]   sw_data;
    logic [KEEP_W-1:0]   sw_keep;
    logic                out_rdy;
    logic                out_busy;
    logic                accept;
    logic                load;

    always_comb begin
        hit      = 1'b0;
        match_ch = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!hit && recv_type == CH_PROTO[16*i +: 16]) begin
                hit      = 1'b1;
                match_ch = CH_W'(i);
            end
        end
    end

    assign route_ch = (state == IDLE) ? match_ch : sel;

    always_comb begin
        route_oh = '0;
        do_swap  = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (route_ch == CH_W'(i)) begin
                route_oh[i] = 1'b1;
                do_swap     = CH_BSWAP[i];
            end
        end
    end

    always_comb begin
        sw_data = '0;
        sw_keep = '0;
        for (int unsigned k = 0; k < KEEP_W; k++) begin
            sw_data[8*k +: 8] = s_axis_tdata[8*(KEEP_W-1-k) +: 8];
            sw_keep[k]        = s_axis_tkeep[KEEP_W-1-k];
        end
    end

    assign out_rdy  = |(out_oh & m_axis_tready);
    assign out_busy = (|out_oh) & ~out_rdy;

    // An unmatched first beat waits for the output like any other first beat.
    assign s_axis_tready = ~rx_axis_reset & ((state == DROP) | ~out_busy);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign load          = accept & (((state == IDLE) & hit) | (state == FWD));

    always_ff @(posedge rx_axis_aclk) begin
        if (rx_axis_reset) begin
            state            <= IDLE;
            sel              <= '0;
            out_oh           <= '0;
            out_data         <= '0;
            out_keep         <= '0;
            out_last         <= 1'b0;
            out_user         <= 1'b0;
            ip_mode_src_addr <= '0;
            ip_mode_dst_addr <= '0;
            drop_pkt_cnt     <= '0;
            err_pkt_cnt      <= '0;
        end else begin
            if (load) begin
                out_oh   <= route_oh;
                out_data <= do_swap ? sw_data : s_axis_tdata;
                out_keep <= do_swap ? sw_keep : s_axis_tkeep;
                out_last <= s_axis_tlast;
                out_user <= s_axis_tuser;
            end else if (out_rdy) begin
                out_oh <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            sel              <= match_ch;
                            ip_mode_src_addr <= recv_src_ip_addr;
                            ip_mode_dst_addr <= recv_dst_ip_addr;
                            if (s_axis_tlast) begin
                                if (s_axis_tuser && err_pkt_cnt != '1)
                                    err_pkt_cnt <= err_pkt_cnt + 32'd1;
                            end else begin
                                state <= FWD;
                            end
                        end else if (s_axis_tlast) begin
                            if (drop_pkt_cnt != '1)
                                drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                FWD: begin
                    if (accept && s_axis_tlast) begin
                        state <= IDLE;
                        if (s_axis_tuser && err_pkt_cnt != '1)
                            err_pkt_cnt <= err_pkt_cnt + 32'd1;
                    end
                end
                DROP: begin
                    if (accept && s_axis_tlast) begin
                        state <= IDLE;
                        if (drop_pkt_cnt != '1)
                            drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = out_oh;
        m_axis_tlast  = '0;
        m_axis_tuser  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (out_oh[i]) begin
                m_axis_tdata[DATA_W*i +: DATA_W] = out_data;
                m_axis_tkeep[KEEP_W*i +: KEEP_W] = out_keep;
                m_axis_tlast[i]                  = out_last;
                m_axis_tuser[i]                  = out_user;
            end
        end
    end

endmodule

// File: tb/tb_us_ip_rx_demux.sv
// Bench for us_ip_rx_demux: vector table, hand-written corner sequences and
// randomized packets checked against a per-channel expected-beat model.
module tb_us_ip_rx_demux;

    localparam int DW = 64;
    localparam int NC = 2;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tuser;
    logic            s_axis_tlast;
    logic [15:0]     recv_type;
    logic [31:0]     recv_src_ip_addr;
    logic [31:0]     recv_dst_ip_addr;
    logic [NC*DW-1:0] m_axis_tdata;
    logic [NC*KW-1:0] m_axis_tkeep;
    logic [NC-1:0]   m_axis_tvalid;
    logic [NC-1:0]   m_axis_tready;
    logic [NC-1:0]   m_axis_tuser;
    logic [NC-1:0]   m_axis_tlast;
    logic [31:0]     ip_mode_src_addr;
    logic [31:0]     ip_mode_dst_addr;
    logic [31:0]     drop_pkt_cnt;
    logic [31:0]     err_pkt_cnt;

    us_ip_rx_demux #(
        .DATA_W  (DW),
        .NUM_CH  (NC),
        .CH_PROTO({16'h0001, 16'h0011}),
        .CH_BSWAP(2'b01)
    ) dut (
        .rx_axis_aclk    (clk),
        .rx_axis_reset   (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tlast    (s_axis_tlast),
        .recv_type       (recv_type),
        .recv_src_ip_addr(recv_src_ip_addr),
        .recv_dst_ip_addr(recv_dst_ip_addr),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tlast    (m_axis_tlast),
        .ip_mode_src_addr(ip_mode_src_addr),
        .ip_mode_dst_addr(ip_mode_dst_addr),
        .drop_pkt_cnt    (drop_pkt_cnt),
        .err_pkt_cnt     (err_pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic [31:0] src;
        logic [31:0] dst;
    } beat_t;

    typedef struct {
        logic [15:0] typ;
        int          n;
        logic        ulast;
        logic        alt;
        int          ech;
        int          drop_after;
        int          err_after;
    } vec_t;

    beat_t expq[NC][$];
    int    checks = 0;
    int    passes = 0;
    int    drop_exp = 0;
    int    err_exp = 0;

    // 0: all ready, 1: random ready, 2: forced to rdy_force
    int        rdy_mode = 0;
    logic [1:0] rdy_force = 2'b11;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       m_axis_tready = 2'($urandom);
            2:       m_axis_tready = rdy_force;
            default: m_axis_tready = 2'b11;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] bswap64(input logic [63:0] d);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = d[8*(7-k) +: 8];
        return r;
    endfunction

    function automatic logic [7:0] krev(input logic [7:0] k);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = k[7-b];
        return r;
    endfunction

    // Channel table as the protocol plan defines it: ch0 = 0x0011 (byte-swapped), ch1 = 0x0001.
    function automatic int ref_ch(input logic [15:0] t);
        if (t == 16'h0011) return 0;
        if (t == 16'h0001) return 1;
        return -1;
    endfunction

    function automatic bit ref_swap(input int ch);
        return ch == 0;
    endfunction

    // Output monitor: handshakes, one-hot valid, stability under backpressure.
    bit          hv = 0;
    int          hch;
    logic [72:0] hbeat;

    always @(negedge clk) begin
        if (rst) begin
            hv = 0;
        end else begin
            chk("onehot_valid", 64'($countones(m_axis_tvalid) <= 1), 64'd1);
            if (hv)
                chk("hold_stable", 64'({m_axis_tvalid[hch], m_axis_tlast[hch],
                    m_axis_tkeep[hch*KW +: KW], m_axis_tdata[hch*DW +: DW]} != {1'b1, hbeat}), 64'd0);
            hv = 0;
            for (int c = 0; c < NC; c++) begin
                if (m_axis_tvalid[c] && !m_axis_tready[c]) begin
                    hv = 1;
                    hch = c;
                    hbeat = {m_axis_tlast[c], m_axis_tkeep[c*KW +: KW], m_axis_tdata[c*DW +: DW]};
                end
                if (m_axis_tvalid[c] && m_axis_tready[c]) begin
                    if (expq[c].size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_beat: ch%0d data %h expected no beat", c, m_axis_tdata[c*DW +: DW]);
                    end else begin
                        beat_t e;
                        e = expq[c].pop_front();
                        chk($sformatf("ch%0d_data", c), m_axis_tdata[c*DW +: DW], e.data);
                        chk($sformatf("ch%0d_keep", c), 64'(m_axis_tkeep[c*KW +: KW]), 64'(e.keep));
                        chk($sformatf("ch%0d_last", c), 64'(m_axis_tlast[c]), 64'(e.last));
                        chk($sformatf("ch%0d_user", c), 64'(m_axis_tuser[c]), 64'(e.user));
                        chk($sformatf("ch%0d_src", c), 64'(ip_mode_src_addr), 64'(e.src));
                        chk($sformatf("ch%0d_dst", c), 64'(ip_mode_dst_addr), 64'(e.dst));
                    end
                end
            end
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u,
                              input logic [15:0] t, input logic [31:0] s, input logic [31:0] ds);
        bit acc;
        int n = 0;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
        recv_type = t; recv_src_ip_addr = s; recv_dst_ip_addr = ds;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                $display("FAIL drive_timeout: got no tready expected accept within 300 cycles");
                $fatal(1);
            end
        end while (!acc);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic push_exp(input int ech, input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic u, input logic [31:0] s, input logic [31:0] ds);
        beat_t b;
        if (ech < 0) return;
        b.data = ref_swap(ech) ? bswap64(d) : d;
        b.keep = ref_swap(ech) ? krev(k) : k;
        b.last = l; b.user = u; b.src = s; b.dst = ds;
        expq[ech].push_back(b);
    endtask

    task automatic send_pkt(input logic [15:0] typ, input int n, input logic [63:0] d0,
                            input logic [7:0] klast, input logic ulast, input int ech,
                            input logic alt, input logic [15:0] alt_type);
        logic [31:0] s, ds;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l, u;
        s = $urandom; ds = $urandom;
        for (int i = 0; i < n; i++) begin
            d = d0 + 64'(i) * 64'h0101010101010101;
            l = (i == n - 1);
            k = l ? klast : 8'hFF;
            u = l ? ulast : 1'b0;
            push_exp(ech, d, k, l, u, s, ds);
            drive_beat(d, k, l, u, (i > 0 && alt) ? alt_type : typ, s, ds);
        end
        if (ech < 0) drop_exp++;
        else if (ulast) err_exp++;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq[0].size() + expq[1].size()) != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 500) $display("FAIL drain_timeout: got %0d beats pending expected 0", expq[0].size() + expq[1].size());
        else passes++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    vec_t tbl[7];

    initial begin
        tbl[0] = '{16'h0001, 2, 1'b0, 1'b1,  1, 0, 0};
        tbl[1] = '{16'h0006, 4, 1'b0, 1'b0, -1, 1, 0};
        tbl[2] = '{16'h0011, 3, 1'b0, 1'b0,  0, 1, 0};
        tbl[3] = '{16'h0011, 1, 1'b1, 1'b0,  0, 1, 1};
        tbl[4] = '{16'h00FF, 1, 1'b0, 1'b0, -1, 2, 1};
        tbl[5] = '{16'h0001, 3, 1'b1, 1'b1,  1, 2, 2};
        tbl[6] = '{16'h0011, 2, 1'b1, 1'b0,  0, 2, 3};

        rst = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        recv_type = '0; recv_src_ip_addr = '0; recv_dst_ip_addr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_drop_cnt", 64'(drop_pkt_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_pkt_cnt), 64'd0);
        chk("rst_src", 64'(ip_mode_src_addr), 64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_tready", 64'(s_axis_tready), 64'd1);
        @(posedge clk);
        #1;

        // UDP to ch0 with byte swap; one-cycle latency and address latch
        push_exp(0, 64'h0001020304050607, 8'hFF, 1'b0, 1'b0, 32'hC0A80001, 32'hC0A80002);
        push_exp(0, 64'h08090A0B0C0D0E0F, 8'hFF, 1'b0, 1'b0, 32'hC0A80001, 32'hC0A80002);
        push_exp(0, 64'h1011121314151617, 8'h0F, 1'b1, 1'b0, 32'hC0A80001, 32'hC0A80002);
        chk("udp_pre_tvalid", 64'(m_axis_tvalid), 64'd0);
        drive_beat(64'h0001020304050607, 8'hFF, 1'b0, 1'b0, 16'h0011, 32'hC0A80001, 32'hC0A80002);
        chk("udp_b0_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("udp_b0_data", m_axis_tdata[63:0], 64'h0706050403020100);
        chk("udp_b0_src", 64'(ip_mode_src_addr), 64'hC0A80001);
        chk("udp_b0_dst", 64'(ip_mode_dst_addr), 64'hC0A80002);
        drive_beat(64'h08090A0B0C0D0E0F, 8'hFF, 1'b0, 1'b0, 16'h0011, 32'hC0A80001, 32'hC0A80002);
        chk("udp_b1_last", 64'(m_axis_tlast[0]), 64'd0);
        drive_beat(64'h1011121314151617, 8'h0F, 1'b1, 1'b0, 16'h0011, 32'hC0A80001, 32'hC0A80002);
        chk("udp_b2_keep", 64'(m_axis_tkeep[7:0]), 64'hF0);
        chk("udp_b2_last", 64'(m_axis_tlast[0]), 64'd1);
        drain();

        // Vector table: routing, type toggle mid-packet, drops, error counting
        for (int r = 0; r < 7; r++) begin
            send_pkt(tbl[r].typ, tbl[r].n, {$urandom, $urandom}, 8'h3F, tbl[r].ulast,
                     tbl[r].ech, tbl[r].alt, 16'h0011);
            drain();
            chk($sformatf("tbl%0d_drop_cnt", r), 64'(drop_pkt_cnt), 64'(tbl[r].drop_after));
            chk($sformatf("tbl%0d_err_cnt", r), 64'(err_pkt_cnt), 64'(tbl[r].err_after));
        end

        // Backpressure on ch0 for 5 cycles mid-packet
        fork
            send_pkt(16'h0011, 8, 64'hA0A1A2A3A4A5A6A7, 8'hFF, 1'b0, 0, 1'b0, 16'h0011);
            begin
                repeat (3) @(posedge clk);
                #2 rdy_force = 2'b10; rdy_mode = 2;
                @(posedge clk);
                #2;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_s_tready", 64'(s_axis_tready), 64'd0);
                end
                rdy_mode = 0;
            end
        join
        drain();

        // Reset after beat 2 of a 4-beat UDP packet, then ICMP with tuser on tlast
        push_exp(0, 64'h1111111111111111, 8'hFF, 1'b0, 1'b0, 32'h0A000001, 32'h0A000002);
        drive_beat(64'h1111111111111111, 8'hFF, 1'b0, 1'b0, 16'h0011, 32'h0A000001, 32'h0A000002);
        drive_beat(64'h2222222222222222, 8'hFF, 1'b0, 1'b0, 16'h0011, 32'h0A000001, 32'h0A000002);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_tready", 64'(s_axis_tready), 64'd0);
        @(posedge clk);
        #1;
        expq[0].delete();
        expq[1].delete();
        drop_exp = 0;
        err_exp = 0;
        @(negedge clk);
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_src", 64'(ip_mode_src_addr), 64'd0);
        chk("midrst_drop_cnt", 64'(drop_pkt_cnt), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        send_pkt(16'h0001, 3, 64'h5555AAAA5555AAAA, 8'h07, 1'b1, 1, 1'b0, 16'h0001);
        drain();
        chk("midrst_err_cnt", 64'(err_pkt_cnt), 64'd1);
        chk("midrst_drop_cnt2", 64'(drop_pkt_cnt), 64'd0);

        // Randomized packets under random output backpressure
        rdy_mode = 1;
        for (int p = 0; p < 60; p++) begin
            logic [15:0] t;
            case ($urandom_range(0, 3))
                0:       t = 16'h0011;
                1:       t = 16'h0001;
                2:       t = 16'h0006;
                default: t = 16'($urandom);
            endcase
            send_pkt(t, $urandom_range(1, 6), {$urandom, $urandom}, 8'($urandom_range(1, 255)),
                     1'($urandom), ref_ch(t), 1'b1, 16'($urandom));
        end
        rdy_mode = 0;
        drain();
        chk("rand_drop_cnt", 64'(drop_pkt_cnt), 64'(drop_exp));
        chk("rand_err_cnt", 64'(err_pkt_cnt), 64'(err_exp));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
